// File: rtl/ay_stereo_mixer_dac_pkg.sv
// Shared encodings and panning weights for the TurboSound stereo mixer.
// pan_terms gives the left/right contribution of one AY channel in a given stereo mode.
package ay_stereo_mixer_dac_pkg;

    localparam int unsigned MIX_W      = 11;
    localparam logic [2:0]  SLOT_BEEP  = 3'd6;
    localparam logic [2:0]  SLOT_LATCH = 3'd7;

    typedef enum logic [1:0] {
        MODE_MONO     = 2'b00,
        MODE_ABC      = 2'b01,
        MODE_ACB      = 2'b10,
        MODE_MONO_ALT = 2'b11
    } stereo_mode_e;

    typedef enum logic [1:0] {
        CHAN_A = 2'd0,
        CHAN_B = 2'd1,
        CHAN_C = 2'd2
    } chan_e;

    typedef struct packed {
        logic [MIX_W-1:0] l;
        logic [MIX_W-1:0] r;
    } pan_terms_t;

    function automatic pan_terms_t pan_terms(input logic [1:0] mode, input logic [1:0] chan,
                                             input logic [7:0] level);
        pan_terms_t       t;
        logic [MIX_W-1:0] x1;
        logic [MIX_W-1:0] x2;
        x1 = {3'b000, level};
        x2 = {2'b00, level, 1'b0};
        t.l = x1;
        t.r = x1;
        case (mode)
            MODE_ABC: begin
                case (chan)
                    CHAN_A:  begin t.l = x2;  t.r = '0; end
                    CHAN_B:  begin t.l = x1;  t.r = x1; end
                    default: begin t.l = '0;  t.r = x2; end
                endcase
            end
            MODE_ACB: begin
                case (chan)
                    CHAN_A:  begin t.l = x2;  t.r = '0; end
                    CHAN_B:  begin t.l = '0;  t.r = x2; end
                    default: begin t.l = x1;  t.r = x1; end
                endcase
            end
            default: begin
                t.l = x1;
                t.r = x1;
            end
        endcase
        return t;
    endfunction

endpackage

// File: rtl/ay_stereo_mixer_dac_sigma_delta_dac1.sv
// First-order sigma-delta 1-bit DAC: the carry out of a W-bit phase accumulator
// is the output bit, giving a ones density of level / 2**W.
module sigma_delta_dac1 #(
    parameter int unsigned W = 11
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic [W-1:0] i_level,
    output logic         o_bit
);

    logic [W:0] r_sd;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_sd <= '0;
        end else begin
            r_sd <= {1'b0, r_sd[W-1:0]} + {1'b0, i_level};
        end
    end

    assign o_bit = r_sd[W];

endmodule

// File: rtl/ay_stereo_mixer_dac.sv
// Dual-AY stereo mixer: an 8-slot sequencer accumulates one channel per clk into
// left/right sums, latches them at slot 7 and feeds two sigma-delta DACs.
module ay_stereo_mixer_dac
    import ay_stereo_mixer_dac_pkg::*;
#(
    parameter int unsigned BEEPER_LEVEL = 255,
    parameter int unsigned SLOTS        = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [23:0]      ay1_chans,
    input  logic [23:0]      ay2_chans,
    input  logic [1:0]       stereo_mode,
    input  logic             disable_turboay,
    input  logic             beeper,
    output logic [MIX_W-1:0] mix_left,
    output logic [MIX_W-1:0] mix_right,
    output logic             mix_valid,
    output logic             dac_left,
    output logic             dac_right
);

    localparam logic [MIX_W-1:0] BEEP_TERM = MIX_W'(BEEPER_LEVEL);
    localparam logic [2:0]       SLOT_LAST = 3'(SLOTS - 1);

    logic [2:0]       r_slot;
    logic [1:0]       r_mode;
    logic             r_dis;
    logic [MIX_W-1:0] r_acc_l;
    logic [MIX_W-1:0] r_acc_r;
    logic [MIX_W-1:0] r_mix_l;
    logic [MIX_W-1:0] r_mix_r;
    logic             r_valid;

    logic [1:0]       w_mode;
    logic             w_dis;
    logic [7:0]       w_level;
    logic [1:0]       w_chan;
    pan_terms_t       w_pan;
    logic [MIX_W-1:0] w_term_l;
    logic [MIX_W-1:0] w_term_r;
    logic [MIX_W:0]   w_sum_l;
    logic [MIX_W:0]   w_sum_r;

    // Slot 0 already uses the mode being captured, so the whole frame sees one mode.
    always_comb begin
        w_mode   = (r_slot == 3'd0) ? stereo_mode : r_mode;
        w_dis    = (r_slot == 3'd0) ? disable_turboay : r_dis;
        w_level  = 8'd0;
        w_chan   = CHAN_A;
        case (r_slot)
            3'd0: begin w_level = ay1_chans[23:16]; w_chan = CHAN_A; end
            3'd1: begin w_level = ay1_chans[15:8];  w_chan = CHAN_B; end
            3'd2: begin w_level = ay1_chans[7:0];   w_chan = CHAN_C; end
            3'd3: begin w_level = w_dis ? 8'd0 : ay2_chans[23:16]; w_chan = CHAN_A; end
            3'd4: begin w_level = w_dis ? 8'd0 : ay2_chans[15:8];  w_chan = CHAN_B; end
            3'd5: begin w_level = w_dis ? 8'd0 : ay2_chans[7:0];   w_chan = CHAN_C; end
            default: begin w_level = 8'd0; w_chan = CHAN_A; end
        endcase
        w_pan    = pan_terms(w_mode, w_chan, w_level);
        w_term_l = w_pan.l;
        w_term_r = w_pan.r;
        if (r_slot == SLOT_BEEP) begin
            w_term_l = beeper ? BEEP_TERM : '0;
            w_term_r = beeper ? BEEP_TERM : '0;
        end
        w_sum_l  = {1'b0, r_acc_l} + {1'b0, w_term_l};
        w_sum_r  = {1'b0, r_acc_r} + {1'b0, w_term_r};
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_slot  <= 3'd0;
            r_mode  <= MODE_MONO;
            r_dis   <= 1'b0;
            r_acc_l <= '0;
            r_acc_r <= '0;
            r_mix_l <= '0;
            r_mix_r <= '0;
            r_valid <= 1'b0;
        end else begin
            r_slot  <= (r_slot == SLOT_LAST) ? 3'd0 : r_slot + 3'd1;
            r_valid <= 1'b0;
            if (r_slot == 3'd0) begin
                r_mode <= stereo_mode;
                r_dis  <= disable_turboay;
            end
            if (r_slot == SLOT_LATCH) begin
                r_mix_l <= r_acc_l;
                r_mix_r <= r_acc_r;
                r_valid <= 1'b1;
                r_acc_l <= '0;
                r_acc_r <= '0;
            end else begin
                r_acc_l <= w_sum_l[MIX_W-1:0];
                r_acc_r <= w_sum_r[MIX_W-1:0];
            end
        end
    end

    a_no_wrap_l: assert property (@(posedge clk) disable iff (!reset_n) !w_sum_l[MIX_W]);
    a_no_wrap_r: assert property (@(posedge clk) disable iff (!reset_n) !w_sum_r[MIX_W]);

    sigma_delta_dac1 #(
        .W(MIX_W)
    ) u_dac_left (
        .clk    (clk),
        .reset_n(reset_n),
        .i_level(r_mix_l),
        .o_bit  (dac_left)
    );

    sigma_delta_dac1 #(
        .W(MIX_W)
    ) u_dac_right (
        .clk    (clk),
        .reset_n(reset_n),
        .i_level(r_mix_r),
        .o_bit  (dac_right)
    );

    assign mix_left  = r_mix_l;
    assign mix_right = r_mix_r;
    assign mix_valid = r_valid;

endmodule

// File: tb/tb_ay_stereo_mixer_dac.sv
// Self-checking bench for ay_stereo_mixer_dac: directed panning cases, random frames
// against an arithmetic mixing model, mode timing, DAC density and mid-frame reset.
module tb_ay_stereo_mixer_dac;

    logic        clk;
    logic        reset_n;
    logic [23:0] ay1_chans;
    logic [23:0] ay2_chans;
    logic [1:0]  stereo_mode;
    logic        disable_turboay;
    logic        beeper;
    logic [10:0] mix_left;
    logic [10:0] mix_right;
    logic        mix_valid;
    logic        dac_left;
    logic        dac_right;

    int checks   = 0;
    int failures = 0;

    ay_stereo_mixer_dac #(
        .BEEPER_LEVEL(255)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .ay1_chans      (ay1_chans),
        .ay2_chans      (ay2_chans),
        .stereo_mode    (stereo_mode),
        .disable_turboay(disable_turboay),
        .beeper         (beeper),
        .mix_left       (mix_left),
        .mix_right      (mix_right),
        .mix_valid      (mix_valid),
        .dac_left       (dac_left),
        .dac_right      (dac_right)
    );

    initial clk = 1'b0;
    always #18 clk = ~clk;

    initial begin
        #20ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Weighted sum of both AYs plus beeper, straight from the panning rules.
    function automatic void model(input logic [1:0] m, input logic dis, input logic bp,
                                  input logic [23:0] a1, input logic [23:0] a2,
                                  output int l, output int r);
        int a, b, c;
        logic [23:0] src;
        l = 0;
        r = 0;
        for (int i = 0; i < 2; i++) begin
            src = (i == 0) ? a1 : (dis ? 24'h0 : a2);
            a = int'(src[23:16]);
            b = int'(src[15:8]);
            c = int'(src[7:0]);
            case (m)
                2'b01:   begin l += 2 * a + b; r += 2 * c + b; end
                2'b10:   begin l += 2 * a + c; r += 2 * b + c; end
                default: begin l += a + b + c; r += a + b + c; end
            endcase
        end
        if (bp) begin
            l += 255;
            r += 255;
        end
    endfunction

    // Drives one frame's inputs from slot 0 and returns what is latched at its slot 7.
    task automatic run_frame(input logic [1:0] m, input logic dis, input logic bp,
                             input logic [23:0] a1, input logic [23:0] a2,
                             output logic [10:0] l, output logic [10:0] r,
                             output logic v, output logic early);
        stereo_mode     = m;
        disable_turboay = dis;
        beeper          = bp;
        ay1_chans       = a1;
        ay2_chans       = a2;
        early           = 1'b0;
        repeat (7) begin
            tick();
            if (mix_valid) early = 1'b1;
        end
        tick();
        v = mix_valid;
        l = mix_left;
        r = mix_right;
    endtask

    task automatic test_reset;
        int n;
        reset_n         = 1'b0;
        ay1_chans       = 24'($urandom);
        ay2_chans       = 24'($urandom);
        stereo_mode     = 2'($urandom);
        disable_turboay = 1'($urandom);
        beeper          = 1'($urandom);
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if ({mix_left, mix_right, mix_valid, dac_left, dac_right} !== 25'd0) begin
                failures++;
                $display("FAIL reset_outputs cycle %0d: got L=%0d R=%0d v=%b dl=%b dr=%b want 0",
                         i, mix_left, mix_right, mix_valid, dac_left, dac_right);
            end
        end
        reset_n = 1'b1;
        for (int p = 0; p < 3; p++) begin
            n = 0;
            do begin
                tick();
                n++;
            end while (!mix_valid && n < 20);
            checks++;
            if (n != 8 || !mix_valid) begin
                failures++;
                $display("FAIL reset_valid_period pulse %0d: got %0d cycles (valid=%b) want 8",
                         p, n, mix_valid);
            end
        end
    endtask

    task automatic test_abc_acb;
        logic [10:0] l, r;
        logic v, e;
        run_frame(2'b01, 1'b0, 1'b0, 24'h102030, 24'h0, l, r, v, e);
        checks++;
        if (!v || e || l !== 11'h040 || r !== 11'h080) begin
            failures++;
            $display("FAIL abc_basic: got L=%h R=%h v=%b early=%b want L=040 R=080 v=1", l, r, v, e);
        end
        run_frame(2'b10, 1'b0, 1'b0, 24'h102030, 24'h0, l, r, v, e);
        checks++;
        if (!v || e || l !== 11'h050 || r !== 11'h070) begin
            failures++;
            $display("FAIL acb_basic: got L=%h R=%h v=%b early=%b want L=050 R=070 v=1", l, r, v, e);
        end
    endtask

    task automatic test_mono_full;
        logic [10:0] l, r;
        logic v, e;
        run_frame(2'b00, 1'b0, 1'b1, 24'hFFFFFF, 24'hFFFFFF, l, r, v, e);
        checks++;
        if (!v || l !== 11'd1785 || r !== 11'd1785) begin
            failures++;
            $display("FAIL mono_full: got L=%0d R=%0d v=%b want 1785", l, r, v);
        end
        run_frame(2'b00, 1'b1, 1'b1, 24'hFFFFFF, 24'hFFFFFF, l, r, v, e);
        checks++;
        if (!v || l !== 11'd1020 || r !== 11'd1020) begin
            failures++;
            $display("FAIL mono_disable_ay2: got L=%0d R=%0d v=%b want 1020", l, r, v);
        end
        run_frame(2'b11, 1'b0, 1'b0, 24'h010203, 24'h040506, l, r, v, e);
        checks++;
        if (!v || l !== 11'd21 || r !== 11'd21) begin
            failures++;
            $display("FAIL mono_mode3: got L=%0d R=%0d v=%b want 21", l, r, v);
        end
    endtask

    task automatic test_random;
        logic [10:0] l, r;
        logic v, e, dis, bp;
        logic [1:0] m;
        logic [23:0] a1, a2;
        int el, er;
        for (int i = 0; i < 24; i++) begin
            m   = 2'($urandom);
            dis = 1'($urandom);
            bp  = 1'($urandom);
            a1  = 24'($urandom);
            a2  = 24'($urandom);
            model(m, dis, bp, a1, a2, el, er);
            run_frame(m, dis, bp, a1, a2, l, r, v, e);
            checks++;
            if (!v || e || l !== 11'(el) || r !== 11'(er)) begin
                failures++;
                $display("FAIL random_frame %0d mode=%0d dis=%b bp=%b: got L=%0d R=%0d v=%b want L=%0d R=%0d",
                         i, m, dis, bp, l, r, v, el, er);
            end
        end
    endtask

    task automatic test_mode_change;
        logic [10:0] l, r;
        logic v, e;
        int el, er;
        stereo_mode     = 2'b01;
        disable_turboay = 1'b0;
        beeper          = 1'b0;
        ay1_chans       = 24'h102030;
        ay2_chans       = 24'h050A0F;
        repeat (3) tick();
        stereo_mode = 2'b10;
        repeat (5) tick();
        model(2'b01, 1'b0, 1'b0, 24'h102030, 24'h050A0F, el, er);
        checks++;
        if (!mix_valid || mix_left !== 11'(el) || mix_right !== 11'(er)) begin
            failures++;
            $display("FAIL mode_change_old_frame: got L=%0d R=%0d v=%b want L=%0d R=%0d",
                     mix_left, mix_right, mix_valid, el, er);
        end
        run_frame(2'b10, 1'b0, 1'b0, 24'h102030, 24'h050A0F, l, r, v, e);
        model(2'b10, 1'b0, 1'b0, 24'h102030, 24'h050A0F, el, er);
        checks++;
        if (!v || l !== 11'(el) || r !== 11'(er)) begin
            failures++;
            $display("FAIL mode_change_new_frame: got L=%0d R=%0d v=%b want L=%0d R=%0d",
                     l, r, v, el, er);
        end
    endtask

    task automatic test_dac_density;
        logic [10:0] l, r;
        logic v, e;
        logic [23:0] a1s [3];
        logic [1:0]  ms  [3];
        int want_l [3];
        int want_r [3];
        int ones_l, ones_r;
        a1s[0] = 24'hFFFF02; ms[0] = 2'b00; want_l[0] = 512; want_r[0] = 512;
        a1s[1] = 24'h000000; ms[1] = 2'b00; want_l[1] = 0;   want_r[1] = 0;
        a1s[2] = 24'h102030; ms[2] = 2'b01; want_l[2] = 64;  want_r[2] = 128;
        for (int k = 0; k < 3; k++) begin
            run_frame(ms[k], 1'b0, 1'b0, a1s[k], 24'h0, l, r, v, e);
            run_frame(ms[k], 1'b0, 1'b0, a1s[k], 24'h0, l, r, v, e);
            ones_l = 0;
            ones_r = 0;
            for (int c = 0; c < 2048; c++) begin
                tick();
                ones_l += int'(dac_left);
                ones_r += int'(dac_right);
            end
            checks++;
            if (ones_l < want_l[k] - 1 || ones_l > want_l[k] + 1 ||
                ones_r < want_r[k] - 1 || ones_r > want_r[k] + 1 ||
                (want_l[k] == 0 && ones_l != 0)) begin
                failures++;
                $display("FAIL dac_density case %0d: got ones L=%0d R=%0d want L=%0d R=%0d (+-1)",
                         k, ones_l, ones_r, want_l[k], want_r[k]);
            end
        end
        run_frame(2'b00, 1'b0, 1'b1, 24'hFFFFFF, 24'hFFFFFF, l, r, v, e);
        run_frame(2'b00, 1'b0, 1'b1, 24'hFFFFFF, 24'hFFFFFF, l, r, v, e);
        ones_l = 0;
        for (int c = 0; c < 2048; c++) begin
            tick();
            ones_l += int'(dac_left);
        end
        checks++;
        if (ones_l < 1784 || ones_l > 1786) begin
            failures++;
            $display("FAIL dac_density_max: got ones=%0d want 1785 (+-1)", ones_l);
        end
    endtask

    task automatic test_reset_midframe;
        int el, er, n;
        logic early;
        stereo_mode     = 2'b01;
        disable_turboay = 1'b0;
        beeper          = 1'b1;
        ay1_chans       = 24'h405060;
        ay2_chans       = 24'h112233;
        repeat (4) tick();
        reset_n = 1'b0;
        tick();
        checks++;
        if ({mix_left, mix_right, mix_valid, dac_left, dac_right} !== 25'd0) begin
            failures++;
            $display("FAIL midframe_reset_clear: got L=%0d R=%0d v=%b dl=%b dr=%b want 0",
                     mix_left, mix_right, mix_valid, dac_left, dac_right);
        end
        tick();
        reset_n = 1'b1;
        n = 0;
        early = 1'b0;
        do begin
            tick();
            n++;
        end while (!mix_valid && n < 20);
        model(2'b01, 1'b0, 1'b1, 24'h405060, 24'h112233, el, er);
        checks++;
        if (n != 8 || mix_left !== 11'(el) || mix_right !== 11'(er)) begin
            failures++;
            $display("FAIL midframe_reset_first_frame: got %0d cycles L=%0d R=%0d want 8 cycles L=%0d R=%0d",
                     n, mix_left, mix_right, el, er);
        end
    endtask

    initial begin
        test_reset();
        test_abc_acb();
        test_mono_full();
        test_random();
        test_mode_change();
        test_dac_density();
        test_reset_midframe();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
